// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and default widths.
// Used by the sequential divider and the Karatsuba multiplier.
package arith_pkg;

   localparam int DIV_NW = 64;
   localparam int DIV_DW = 32;
   localparam int MUL_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FINISH
   } div_state_t;

endpackage

// File: rtl/div64by32_seq_if.sv
// Start/valid handshake bundle between a controller and the
// sequential divider: operands in, results and status out.
interface div64by32_seq_if
   import arith_pkg::*;
#(
   parameter int NW = DIV_NW,
   parameter int DW = DIV_DW
);

   logic          start;
   logic [NW-1:0] N;
   logic [DW-1:0] D;
   logic [NW-1:0] Q;
   logic [DW-1:0] R;
   logic          valid_out;
   logic          busy;
   logic          div_by_zero;

   modport master (
      output start, N, D,
      input  Q, R, valid_out, busy, div_by_zero
   );

   modport slave (
      input  start, N, D,
      output Q, R, valid_out, busy, div_by_zero
   );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next
// dividend bit, trial-subtract the divisor, keep it if non-negative.
module div_step #(
   parameter int DW = 32
) (
   input  logic [DW:0]   rem_i,
   input  logic          q_msb_i,
   input  logic [DW-1:0] d_i,
   output logic [DW:0]   rem_o,
   output logic          q_o
);

   logic [DW+1:0] shl;
   logic [DW+1:0] trial;

   // Trial subtract one bit wider than the shifted remainder.
   always_comb begin
      shl   = {rem_i, q_msb_i};
      trial = shl - {2'b00, d_i};
      q_o   = ~trial[DW+1];
      rem_o = q_o ? trial[DW:0] : shl[DW:0];
   end

endmodule

// File: rtl/div64by32_seq.sv
// Sequential 64/32 restoring divider, one quotient bit per cycle.
// The dividend register doubles as the quotient shift register.
module div64by32_seq
   import arith_pkg::*;
#(
   parameter int NW = DIV_NW,
   parameter int DW = DIV_DW
) (
   input logic              clk,
   input logic              rst,
   div64by32_seq_if.slave   bus
);

   localparam int CW = $clog2(NW) + 1;

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW:0]   rem_q, rem_d;
   logic [NW-1:0] quo_q, quo_d;
   logic [DW-1:0] dvs_q, dvs_d;
   logic          zero_q, zero_d;
   logic [NW-1:0] q_q, q_d;
   logic [DW-1:0] r_q, r_d;
   logic          vld_q, vld_d;
   logic          dbz_q, dbz_d;

   logic [DW:0]   step_rem;
   logic          step_q;

   div_step #(.DW(DW)) u_step (
      .rem_i   (rem_q),
      .q_msb_i (quo_q[NW-1]),
      .d_i     (dvs_q),
      .rem_o   (step_rem),
      .q_o     (step_q)
   );

   // Next-state, datapath and result capture for the three-state FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      zero_d  = zero_q;
      q_d     = q_q;
      r_d     = r_q;
      vld_d   = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               quo_d   = bus.N;
               dvs_d   = bus.D;
               rem_d   = '0;
               cnt_d   = '0;
               zero_d  = (bus.D == '0);
               state_d = zero_d ? FINISH : ITER;
            end
         end
         ITER: begin
            rem_d = step_rem;
            quo_d = {quo_q[NW-2:0], step_q};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NW - 1))
               state_d = FINISH;
         end
         FINISH: begin
            vld_d   = 1'b1;
            dbz_d   = zero_q;
            state_d = IDLE;
            if (zero_q) begin
               q_d = '1;
               r_d = quo_q[DW-1:0];
            end else begin
               q_d = quo_q;
               r_d = rem_q[DW-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         zero_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         vld_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         zero_q  <= zero_d;
         q_q     <= q_d;
         r_q     <= r_d;
         vld_q   <= vld_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.Q           = q_q;
   assign bus.R           = r_q;
   assign bus.valid_out   = vld_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/div64by32_seq.md
# div64by32_seq

Sequential restoring divider producing a 64-bit quotient and 32-bit remainder from a 64-bit dividend and a 32-bit divisor, retiring one quotient bit per cycle. It is the inverse companion to the 32x32 Karatsuba multiplier in the arithmetic datapath. It uses the same single-cycle `start` / one-cycle `valid_out` handshake, so a controller can issue multiply and divide operations through identical sequencing logic.

## Interface
- `NW`, default 64: dividend and quotient width.
- `DW`, default 32: divisor and remainder width.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0, sampled on the `clk` rising edge).
- `start`  in  1  request; sampled only in IDLE.
- `N`  in  NW  dividend; captured with `start`.
- `D`  in  DW  divisor; captured with `start`.
- `Q`  out  NW  quotient; reset 0.
- `R`  out  DW  remainder; reset 0.
- `valid_out`  out  1  one-cycle completion pulse; reset 0.
- `busy`  out  1  high from the edge that accepts `start` through the FINISH state; reset 0.
- `div_by_zero`  out  1  flag qualified by `valid_out`; reset 0.

## Operation
- States: IDLE, ITER, FINISH.
- IDLE:
  - On `start`=1, latch `N` into the dividend/quotient shift register and `D` into the divisor register, clear the partial remainder (DW+1 bits), and set the counter to 0.
  - If `D`=0, go to FINISH with the zero flag set; otherwise go to ITER.
- ITER, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Form trial = rem − {1'b0, D}.
  - If the trial result is non-negative (MSB 0), rem ← trial and quo[0] ← 1; else quo[0] ← 0.
  - The counter increments each step. After step NW−1 (counter 63), go to FINISH.
- FINISH:
  - Register `Q` ← quo and `R` ← rem[DW−1:0].
  - `div_by_zero` ← zero flag; `valid_out` ← 1.
  - Return to IDLE.
- Divide by zero: `Q` = all ones, `R` = `N[DW−1:0]`, `div_by_zero` = 1.
- `valid_out` defaults to 0 every cycle and is never high for two consecutive cycles.
- `Q`, `R` and `div_by_zero` hold their values until the next FINISH.
- Width rules:
  - The remainder datapath is DW+1 bits, so the subtraction never overflows.
  - The final remainder is always < D.
  - The counter is 7 bits wide: $clog2(NW)+1.
- `start` while `busy` is ignored. It is neither queued nor allowed to corrupt the operands.
- `rst`=0 in any state, including mid-ITER, returns to IDLE on that edge:
  - All outputs go to 0; the internal registers are cleared.
  - An operation in flight is discarded, and no `valid_out` pulse is issued for it.

## Timing
- Let the edge that samples `start`=1 in IDLE be E0.
- Normal operation:
  - Iterations occur on E1..E64.
  - FINISH is on E65; `valid_out` and the results are visible after E65 for exactly one cycle.
  - Latency is 65 cycles, start edge to valid edge.
- Divide by zero: FINISH on E1, `valid_out` visible after E1. Latency is 1 cycle.
- `busy` rises after E0 and falls after the FINISH edge (E65, or E1 for divide by zero).
- Back-to-back operation: `start` sampled on the edge after FINISH (state is IDLE) is accepted. Peak throughput is one divide per 66 cycles.
- Inputs `N` and `D` are don't-care except at the E0 sample.

## Structure
- Package `arith_pkg`:
  - `div_state_t` enum (IDLE, ITER, FINISH).
  - Localparams for the default widths, shared with the multiplier.
- Sub-module `div_step`: a combinational single restoring step.
  - Inputs: rem (DW+1), the incoming quotient MSB, and the divisor.
  - Outputs: next rem and the quotient bit.
  - Sized by `DW`, so it can later be instantiated twice per cycle for a radix-4 variant.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- N=100, D=7, one `start` pulse -> `valid_out` 65 cycles later; Q=14, R=2, `div_by_zero`=0; `busy` high for exactly 65 cycles.
- N=0xFFFF_FFFF_FFFF_FFFF, D=0xFFFF_FFFF -> Q=0x0000_0001_0000_0001, R=0. Then N=0xFFFF_FFFF_FFFF_FFFF, D=1 -> Q=all ones, R=0.
- N=5, D=9 -> Q=0, R=5. Then N=0x1234_5678_9ABC_DEF0, D=0 -> `valid_out` 1 cycle after start; Q=all ones, R=0x9ABC_DEF0, `div_by_zero`=1.
- Pulse `start` with new operands at cycles 10, 30 and 64 of a busy operation -> ignored; the first result is unchanged; no extra `valid_out`.
- Drive `rst`=0 for one cycle at iteration 40, then start N=1000, D=10 -> no pulse for the aborted operation; all outputs 0 after reset; Q=100, R=0 after 65 cycles.
- Randomized back-to-back run: each `start` issued the cycle after `valid_out` -> 500 operations match a reference model, one result every 66 cycles.
